// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, frame and counter widths,
// and the 2-of-3 vote used by the optional majority sampler.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int CNT_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_START = 3'b010,
    ST_DATA  = 3'b001,
    ST_STOP  = 3'b100
  } uart_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous, idle-high input.
// Both flops reset to 1 so a reset line never looks like a start bit.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver with a one-cycle valid strobe per byte.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 vote at every sample point (needs BD_DIVIDER >= 8).
module uart_rx #(
  parameter int BD_DIVIDER = 2500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       out_ready,
  output logic       frame_err,
  output logic       busy
);

  import uart_pkg::*;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BD_DIVIDER / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BD_DIVIDER - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

  uart_state_t            state;
  logic [CNT_W-1:0]       clk_count;
  logic [2:0]             bit_index;
  logic [DATA_BITS-1:0]   shift;
  logic                   rx_s;
  logic                   sample;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // hist[0] is rx_s one cycle ago, hist[1] two cycles ago: votes over S-2, S-1, S.
  logic [1:0] hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= 2'b11;
    end else begin
      hist <= {hist[0], rx_s};
    end
  end

  assign sample = maj3(hist[1], hist[0], rx_s);
`else
  assign sample = rx_s;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      clk_count <= '0;
      bit_index <= '0;
      shift     <= '0;
      data_out  <= '0;
      out_ready <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_ready <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          clk_count <= '0;
          if (!rx_s) begin
            state <= ST_START;
            busy  <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end

        ST_START: begin
          if (clk_count == HALF_LAST) begin
            clk_count <= '0;
            bit_index <= '0;
            if (!sample) begin
              state <= ST_DATA;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            clk_count <= clk_count + CNT_W'(1);
          end
        end

        ST_DATA: begin
          if (clk_count == BIT_LAST) begin
            clk_count         <= '0;
            shift[bit_index]  <= sample;
            if (bit_index == LAST_BIT) begin
              state <= ST_STOP;
            end else begin
              bit_index <= bit_index + 3'd1;
            end
          end else begin
            clk_count <= clk_count + CNT_W'(1);
          end
        end

        // Leave at mid-stop so a back-to-back start edge is never missed.
        ST_STOP: begin
          if (clk_count == BIT_LAST) begin
            clk_count <= '0;
            state     <= ST_IDLE;
            busy      <= 1'b0;
            if (sample) begin
              data_out  <= shift;
              out_ready <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            clk_count <= clk_count + CNT_W'(1);
          end
        end

        default: begin
          state     <= ST_IDLE;
          clk_count <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed and random 8N1 frames checked
// against a frame-level model of byte values and strobe times.
module tb_uart_rx;

  localparam int T = 16;
  // Line edge to strobe: two synchronizer flops, the detection edge, then half a bit plus nine bits.
  localparam int STROBE_OFS = 3 + T / 2 + 9 * T;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       out_ready;
  logic       frame_err;
  logic       busy;

  uart_rx #(.BD_DIVIDER(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic [7:0] data;
  } evt_t;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  evt_t rdy_q[$];
  int   err_q[$];
  int   busy_cycles = 0;
  int   double_pulses = 0;
  logic prev_rdy = 1'b0;
  logic prev_err = 1'b0;

  always @(posedge clk) cyc++;

  // Observe outputs half a cycle after each active edge.
  always @(negedge clk) begin
    if (out_ready === 1'b1) rdy_q.push_back('{cyc, data_out});
    if (frame_err === 1'b1) err_q.push_back(cyc);
    if (busy === 1'b1) busy_cycles++;
    if ((out_ready === 1'b1 && prev_rdy === 1'b1) || (frame_err === 1'b1 && prev_err === 1'b1))
      double_pulses++;
    prev_rdy = out_ready;
    prev_err = frame_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    rdy_q.delete();
    err_q.delete();
    busy_cycles = 0;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; drives one frame. glitch_bit inverts one cycle at that data bit's
  // centre; abort_bit asserts rst when that data bit begins and abandons the frame.
  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int glitch_bit,
                            input int abort_bit, output int start_cyc);
    logic [9:0] bits;
    bits = {stop_val, b, 1'b0};
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      if (abort_bit >= 0 && i == abort_bit + 1) begin
        rst = 1'b1;
        @(negedge clk);
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_out_ready", 32'(out_ready), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        repeat (3) @(negedge clk);
        rx  = 1'b1;
        rst = 1'b0;
        return;
      end
      for (int j = 0; j < T; j++) begin
        if (glitch_bit >= 0 && i == glitch_bit + 1 && j == T / 2) rx = ~bits[i];
        else rx = bits[i];
        @(negedge clk);
      end
    end
  endtask

  initial begin
    int         s0;
    int         s1;
    logic [7:0] last_good;
    logic [7:0] glitch_exp;
    evt_t       exp_q[$];
    int         nrand;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data_out", 32'(data_out), 32'h0);
    check("reset_out_ready", 32'(out_ready), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    idle(5);

    $display("[TB] clean frame 0xA5");
    clear_obs();
    send_frame(8'hA5, 1'b1, -1, -1, s0);
    idle(3 * T);
    check("a5_count", 32'(rdy_q.size()), 32'd1);
    if (rdy_q.size() >= 1) begin
      check("a5_time", 32'(rdy_q[0].at), 32'(s0 + STROBE_OFS));
      check("a5_data", 32'(rdy_q[0].data), 32'hA5);
    end
    check("a5_no_err", 32'(err_q.size()), 32'd0);
    check("a5_busy_len", 32'(busy_cycles), 32'(T / 2 + 9 * T));

    $display("[TB] back-to-back 0x00, 0xFF");
    clear_obs();
    send_frame(8'h00, 1'b1, -1, -1, s0);
    send_frame(8'hFF, 1'b1, -1, -1, s1);
    idle(3 * T);
    check("b2b_count", 32'(rdy_q.size()), 32'd2);
    if (rdy_q.size() >= 2) begin
      check("b2b_gap", 32'(rdy_q[1].at - rdy_q[0].at), 32'(10 * T));
      check("b2b_first_time", 32'(rdy_q[0].at), 32'(s0 + STROBE_OFS));
      check("b2b_data0", 32'(rdy_q[0].data), 32'h00);
      check("b2b_data1", 32'(rdy_q[1].data), 32'hFF);
    end

    $display("[TB] random frames");
    clear_obs();
    exp_q.delete();
    nrand = 8;
    for (int n = 0; n < nrand; n++) begin
      logic [7:0] rb;
      rb = 8'($urandom);
      send_frame(rb, 1'b1, -1, -1, s0);
      exp_q.push_back('{s0 + STROBE_OFS, rb});
      idle(int'($urandom_range(0, 6)));
    end
    idle(3 * T);
    check("rand_count", 32'(rdy_q.size()), 32'(nrand));
    for (int n = 0; n < nrand && n < rdy_q.size(); n++) begin
      check("rand_time", 32'(rdy_q[n].at), 32'(exp_q[n].at));
      check("rand_data", 32'(rdy_q[n].data), 32'(exp_q[n].data));
    end
    last_good = exp_q[nrand - 1].data;

    $display("[TB] stop bit low on 0x3C");
    clear_obs();
    send_frame(8'h3C, 1'b0, -1, -1, s0);
    idle(3 * T);
    check("ferr_count", 32'(err_q.size()), 32'd1);
    if (err_q.size() >= 1) check("ferr_time", 32'(err_q[0]), 32'(s0 + STROBE_OFS));
    check("ferr_no_ready", 32'(rdy_q.size()), 32'd0);
    check("ferr_data_kept", 32'(data_out), 32'(last_good));

    $display("[TB] 4-cycle start glitch");
    clear_obs();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(3 * T);
    check("glitch_busy_len", 32'(busy_cycles), 32'd8);
    check("glitch_no_ready", 32'(rdy_q.size()), 32'd0);
    check("glitch_no_err", 32'(err_q.size()), 32'd0);

    $display("[TB] reset during frame 0x5A, then 0x81");
    clear_obs();
    send_frame(8'h5A, 1'b1, -1, 4, s0);
    idle(2 * T);
    send_frame(8'h81, 1'b1, -1, -1, s1);
    idle(3 * T);
    check("rst_frame_count", 32'(rdy_q.size()), 32'd1);
    if (rdy_q.size() >= 1) begin
      check("rst_frame_data", 32'(rdy_q[0].data), 32'h81);
      check("rst_frame_time", 32'(rdy_q[0].at), 32'(s1 + STROBE_OFS));
    end
    check("rst_frame_no_err", 32'(err_q.size()), 32'd0);

    $display("[TB] sample-point glitch on bit 3 of 0xF0");
`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'hF0;
`else
    glitch_exp = 8'hF0 ^ 8'h08;
`endif
    clear_obs();
    send_frame(8'hF0, 1'b1, 3, -1, s0);
    idle(3 * T);
    check("bitglitch_count", 32'(rdy_q.size()), 32'd1);
    if (rdy_q.size() >= 1) check("bitglitch_data", 32'(rdy_q[0].data), 32'(glitch_exp));

    check("no_double_pulse", 32'(double_pulses), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
